// File: rtl/crypt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crypt_pkg
// Purpose  : Shared types and constants for the hardware encryption sequencer:
//            one-hot state encoding, data-memory map, the ASCII space used
//            as both pad character and plaintext offset, and a parity helper.
// Ports    : (package, none)
// Revision : 1.0  initial release
// ============================================================================
package crypt_pkg;

    // One-hot state encoding; ack/busy decode straight from single flops.
    typedef enum logic [7:0] {
        IDLE    = 8'b0000_0001,
        LD_PRE  = 8'b0000_0010,
        LD_PTRN = 8'b0000_0100,
        LD_SEED = 8'b0000_1000,
        LD_INIT = 8'b0001_0000,
        RD      = 8'b0010_0000,
        WR      = 8'b0100_0000,
        DONE    = 8'b1000_0000
    } state_t;

    // Bit positions of the one-hot states.
    localparam int c_idle_bit    = 0;
    localparam int c_ld_init_bit = 4;
    localparam int c_wr_bit      = 6;
    localparam int c_done_bit    = 7;

    // Data-memory map.
    localparam int c_msg_base = 0;
    localparam int c_msg_max  = 52;
    localparam int c_out_base = 64;
    localparam int c_out_len  = 64;
    localparam int c_cfg_pre  = 61;
    localparam int c_cfg_ptrn = 62;
    localparam int c_cfg_seed = 63;
    localparam int c_pre_min  = 10;

    localparam logic [7:0] c_space = 8'h20;

    // Even-parity bit over the 7 cipher bits (becomes bit 7 of the output).
    function automatic logic parity7(input logic [6:0] v);
        return ^v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crypt_sequencer_lfsr7.sv
`default_nettype none
// ============================================================================
// Module   : lfsr7
// Purpose  : 7-bit Fibonacci-style LFSR with programmable tap pattern.
//            A zero seed is replaced by 7'h01 so the register cannot start
//            in the all-zero lock-up state.
// Ports    : clk   - clock
//            init  - asynchronous active-high reset (register -> 0)
//            load  - load seed (takes priority over step)
//            seed  - initial state
//            step  - advance one position
//            ptrn  - tap pattern (feedback = XOR of tapped bits)
//            state - current register value
// Revision : 1.0  initial release
// ============================================================================
module lfsr7 (
    input  logic       clk,
    input  logic       init,
    input  logic       load,
    input  logic [6:0] seed,
    input  logic       step,
    input  logic [6:0] ptrn,
    output logic [6:0] state
);

    logic [6:0] r_lfsr;

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_lfsr <= 7'h00;
        end else if (load) begin
            r_lfsr <= (seed == 7'h00) ? 7'h01 : seed;
        end else if (step) begin
            // A zero tap pattern shifts in zeros; intentionally not guarded.
            r_lfsr <= {r_lfsr[5:0], ^(r_lfsr & ptrn)};
        end
    end

    assign state = r_lfsr;

endmodule
`default_nettype wire

// File: rtl/crypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : crypt_sequencer
// Purpose  : Hardware message encryptor. Loads pre_length / tap pattern /
//            seed from data memory, then emits OUT_LEN parity-tagged bytes:
//            preamble spaces, the message, then trailing spaces, each
//            offset by 0x20 and XORed with a stepping 7-bit LFSR.
// Ports    : clk          - clock, rising edge
//            init         - asynchronous active-high reset
//            req          - low launches a run, high holds/returns to idle
//            ack          - run complete, held until req goes high
//            busy         - run in progress
//            mem_addr     - data-memory address
//            mem_rd_en    - read strobe (data returns next cycle)
//            mem_rd_data  - read data
//            mem_wr_en    - write strobe
//            mem_wr_data  - encrypted byte
// Revision : 1.0  initial release
// ============================================================================
module crypt_sequencer
    import crypt_pkg::*;
#(
    parameter int AW       = 8,
    parameter int MSG_BASE = c_msg_base,
    parameter int MSG_MAX  = c_msg_max,
    parameter int OUT_BASE = c_out_base,
    parameter int OUT_LEN  = c_out_len,
    parameter int CFG_PRE  = c_cfg_pre,
    parameter int CFG_PTRN = c_cfg_ptrn,
    parameter int CFG_SEED = c_cfg_seed,
    parameter int PRE_MIN  = c_pre_min
) (
    input  logic          clk,
    input  logic          init,
    input  logic          req,
    output logic          ack,
    output logic          busy,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd_en,
    input  logic [7:0]    mem_rd_data,
    output logic          mem_wr_en,
    output logic [7:0]    mem_wr_data
);

    state_t     r_state;
    state_t     w_state_next;
    logic [6:0] r_i;
    logic [6:0] w_i_next;
    logic [3:0] r_pre;
    logic [3:0] w_pre_cap;
    logic [6:0] r_ptrn;
    logic       r_msg;
    logic [6:0] w_k_next;
    logic       w_msg_next;
    logic [6:0] w_lfsr;
    logic [7:0] w_ch;
    logic [7:0] w_p;
    logic [6:0] w_c;
    logic       w_unused_p7;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (!req) w_state_next = LD_PRE;
            LD_PRE:  w_state_next = LD_PTRN;
            LD_PTRN: w_state_next = LD_SEED;
            LD_SEED: w_state_next = LD_INIT;
            LD_INIT: w_state_next = RD;
            RD:      w_state_next = WR;
            WR:      w_state_next = (r_i == 7'(OUT_LEN - 1)) ? DONE : RD;
            DONE:    if (req) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // ----------------------------------------------------------- datapath
    // Byte index for the upcoming RD cycle, used to decide the read early so
    // the read strobe can be registered on entry to RD.
    always_comb begin
        w_i_next = r_i;
        if (r_state == LD_INIT) begin
            w_i_next = 7'd0;
        end else if (r_state == WR) begin
            w_i_next = r_i + 7'd1;
        end
    end

    assign w_k_next   = w_i_next - {3'b000, r_pre};
    assign w_msg_next = (w_i_next >= {3'b000, r_pre}) && (w_k_next < 7'(MSG_MAX));
    assign w_pre_cap  = (mem_rd_data[3:0] < 4'(PRE_MIN)) ? 4'(PRE_MIN) : mem_rd_data[3:0];

    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            r_i       <= 7'd0;
            r_pre     <= 4'd0;
            r_ptrn    <= 7'd0;
            r_msg     <= 1'b0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
        end else begin
            r_i <= w_i_next;
            if (r_state == LD_PTRN) r_pre  <= w_pre_cap;
            if (r_state == LD_SEED) r_ptrn <= mem_rd_data[6:0];
            if (w_state_next == RD) r_msg  <= w_msg_next;

            // Memory strobes are registered on entry to the state that owns
            // the access, so each is a clean flop output for the whole cycle.
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            mem_addr  <= '0;
            unique case (w_state_next)
                LD_PRE: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= AW'(CFG_PRE);
                end
                LD_PTRN: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= AW'(CFG_PTRN);
                end
                LD_SEED: begin
                    mem_rd_en <= 1'b1;
                    mem_addr  <= AW'(CFG_SEED);
                end
                RD: begin
                    mem_rd_en <= w_msg_next;
                    mem_addr  <= w_msg_next ? AW'(MSG_BASE) + AW'(w_k_next) : '0;
                end
                WR: begin
                    mem_wr_en <= 1'b1;
                    mem_addr  <= AW'(OUT_BASE) + AW'(r_i);
                end
                default: ;
            endcase
        end
    end

    lfsr7 u_lfsr (
        .clk   (clk),
        .init  (init),
        .load  (r_state[c_ld_init_bit]),
        .seed  (mem_rd_data[6:0]),
        .step  (r_state[c_wr_bit]),
        .ptrn  (r_ptrn),
        .state (w_lfsr)
    );

    // The message byte read in RD only arrives during WR (synchronous DM),
    // so the cipher byte is formed from flop outputs and the returned data
    // within the WR cycle, and forced to zero outside it.
    assign w_ch        = r_msg ? mem_rd_data : c_space;
    assign w_p         = w_ch - c_space;
    assign w_c         = w_p[6:0] ^ w_lfsr;
    assign w_unused_p7 = w_p[7];
    assign mem_wr_data = r_state[c_wr_bit] ? {parity7(w_c), w_c} : 8'h00;

    assign ack  = r_state[c_done_bit];
    assign busy = ~(r_state[c_idle_bit] | r_state[c_done_bit]);

endmodule
`default_nettype wire

// File: tb/tb_crypt_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_crypt_sequencer
// Purpose  : Self-checking bench for crypt_sequencer. A behavioural data
//            memory serves the DUT; expected output bytes come from a
//            loop-level reference model of the encryption rules.
// Revision : 1.0  initial release
// ============================================================================
module tb_crypt_sequencer;

    logic       clk;
    logic       init;
    logic       req;
    logic       ack;
    logic       busy;
    logic [7:0] mem_addr;
    logic       mem_rd_en;
    logic [7:0] rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;

    logic [7:0] dm  [256];
    logic [7:0] img [256];
    logic       bd_load;

    logic [7:0] msg     [52];
    logic [7:0] exp_out [64];
    logic [7:0] wr_log  [$];
    int         ovl_total;
    int         total;
    int         bad;

    crypt_sequencer dut (
        .clk         (clk),
        .init        (init),
        .req         (req),
        .ack         (ack),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_data (rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: synchronous read, write on rising edge, backdoor image load.
    always @(posedge clk) begin
        if (bd_load) begin
            for (int j = 0; j < 256; j++) dm[j] <= img[j];
        end else begin
            if (mem_wr_en) dm[mem_addr] <= mem_wr_data;
            if (mem_rd_en) rd_data <= dm[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (mem_wr_en) wr_log.push_back(mem_addr);
        if (mem_wr_en && mem_rd_en) ovl_total++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Reference model: encrypt msg[] under the given configuration bytes.
    task automatic model(input logic [7:0] pre_b, input logic [7:0] ptrn_b, input logic [7:0] seed_b);
        int         pre;
        int         k;
        logic [6:0] s;
        logic [7:0] ch;
        logic [7:0] p;
        logic [6:0] c;
        pre = int'(pre_b & 8'h0f);
        if (pre < 10) pre = 10;
        s = seed_b[6:0];
        if (s == 7'h00) s = 7'h01;
        for (int i = 0; i < 64; i++) begin
            k  = i - pre;
            ch = 8'h20;
            if (i >= pre && k < 52) ch = msg[k];
            p  = ch - 8'h20;
            c  = p[6:0] ^ s;
            exp_out[i] = {^c, c};
            s = {s[5:0], ^(s & ptrn_b[6:0])};
        end
    endtask

    task automatic load_image(input logic [7:0] pre_b, input logic [7:0] ptrn_b, input logic [7:0] seed_b);
        for (int j = 0; j < 256; j++) img[j] = 8'($urandom);
        for (int j = 0; j < 52; j++) img[j] = msg[j];
        img[61] = pre_b;
        img[62] = ptrn_b;
        img[63] = seed_b;
        for (int j = 64; j < 128; j++) img[j] = 8'hEE;
        @(negedge clk) bd_load = 1'b1;
        @(negedge clk) bd_load = 1'b0;
    endtask

    // Launch a run, wait for ack, check latency, traffic and output bytes.
    // Leaves req low and ack high.
    task automatic do_run(input string tag, input logic [7:0] pre_b, input logic [7:0] ptrn_b,
                          input logic [7:0] seed_b, input logic [7:0] mpre, input logic [7:0] mseed,
                          input bit wiggle);
        int n;
        int start_wr;
        int ovl0;
        int errs;
        load_image(pre_b, ptrn_b, seed_b);
        model(mpre, ptrn_b, mseed);
        start_wr = wr_log.size();
        ovl0     = ovl_total;
        req      = 1'b0;
        n        = 0;
        while (n < 300) begin
            @(posedge clk);
            @(negedge clk);
            if (ack) break;
            req = wiggle ? 1'($urandom) : 1'b0;
            n++;
        end
        req = 1'b0;
        check({tag, " ack_edge"}, n, 132);
        check({tag, " busy_done"}, busy, 1'b0);
        check({tag, " wr_count"}, wr_log.size() - start_wr, 64);
        errs = 0;
        for (int j = 0; j < 64 && start_wr + j < wr_log.size(); j++)
            if (wr_log[start_wr + j] != 8'(64 + j)) errs++;
        check({tag, " wr_order_errs"}, errs, 0);
        check({tag, " rd_wr_overlap"}, ovl_total - ovl0, 0);
        for (int j = 0; j < 64; j++)
            check($sformatf("%s byte%0d", tag, j), dm[64 + j], exp_out[j]);
    endtask

    task automatic release_req(input string tag);
        @(negedge clk) req = 1'b1;
        @(negedge clk);
        check({tag, " ack_drop"}, ack, 1'b0);
    endtask

    task automatic set_msg_str(input string s);
        for (int j = 0; j < 52; j++) msg[j] = (j < s.len()) ? 8'(s[j]) : 8'h20;
    endtask

    initial begin
        int n;
        int start_wr;
        total     = 0;
        bad       = 0;
        ovl_total = 0;
        bd_load   = 1'b0;
        rd_data   = 8'h00;
        init      = 1'b1;
        req       = 1'($urandom);

        // Reset behaviour with random req.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk) req = 1'($urandom);
            check("rst ack", ack, 1'b0);
            check("rst busy", busy, 1'b0);
            check("rst wr_en", mem_wr_en, 1'b0);
            check("rst rd_en", mem_rd_en, 1'b0);
        end
        check("rst addr", mem_addr, 8'h00);
        check("rst wr_data", mem_wr_data, 8'h00);

        // Leave reset with req high: no traffic.
        req = 1'b1;
        @(negedge clk) init = 1'b0;
        start_wr = wr_log.size();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (busy || mem_rd_en || mem_wr_en) n = 1;
        end
        check("idle traffic", {busy, mem_rd_en, mem_wr_en}, 3'b000);
        check("idle writes", wr_log.size() - start_wr, 0);

        // Nominal run.
        set_msg_str("Mr. Watson, come here. I want to see you.");
        do_run("nominal", 8'd10, 8'h60, 8'h01, 8'd10, 8'h01, 1'b0);

        // Handshake: req held low in DONE keeps ack, no new run.
        start_wr = wr_log.size();
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("hold ack c%0d", c), ack, 1'b1);
        end
        check("hold writes", wr_log.size() - start_wr, 0);
        release_req("hold");
        do_run("second seed", 8'd10, 8'h60, 8'h33, 8'd10, 8'h33, 1'b0);
        release_req("second");

        // Padding run.
        do_run("padding", 8'd15, 8'h7B, 8'h5A, 8'd15, 8'h5A, 1'b0);
        release_req("padding");

        // Clamp and zero seed: expectations taken from the pre=10 / seed=1 case.
        do_run("clamp", 8'd3, 8'h60, 8'h01, 8'd10, 8'h01, 1'b0);
        release_req("clamp");
        do_run("zero seed", 8'd10, 8'h60, 8'h00, 8'd10, 8'h01, 1'b0);
        release_req("zero seed");

        // Random configurations and messages; some with req wiggling while busy.
        for (int r = 0; r < 4; r++) begin
            logic [7:0] pb;
            logic [7:0] tb_ptrn;
            logic [7:0] sb;
            for (int j = 0; j < 52; j++) msg[j] = 8'($urandom);
            pb      = 8'($urandom);
            tb_ptrn = 8'($urandom);
            sb      = 8'($urandom);
            do_run($sformatf("rand%0d", r), pb, tb_ptrn, sb, pb, sb, r[0]);
            release_req($sformatf("rand%0d", r));
        end

        // Abort during byte 30 write.
        set_msg_str("Mr. Watson, come here. I want to see you.");
        load_image(8'd12, 8'h60, 8'h21);
        model(8'd12, 8'h60, 8'h21);
        req = 1'b0;
        n   = 0;
        while (n < 300 && !(mem_wr_en && mem_addr == 8'd94)) begin
            @(negedge clk);
            n++;
        end
        check("abort reached", n < 300, 1'b1);
        #1 init = 1'b1;
        #1;
        check("abort wr_en", mem_wr_en, 1'b0);
        check("abort rd_en", mem_rd_en, 1'b0);
        check("abort ack", ack, 1'b0);
        check("abort busy", busy, 1'b0);
        req = 1'b1;
        @(negedge clk);
        check("abort byte29", dm[93], exp_out[29]);
        check("abort byte30", dm[94], 8'hEE);
        init = 1'b0;
        @(negedge clk);
        do_run("rerun", 8'd12, 8'h60, 8'h21, 8'd12, 8'h21, 1'b0);
        release_req("rerun");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
